// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-ported data memory between the
// pipeline M-stage (core) and an external host port. The core normally has
// priority; a starvation counter forces a one-cycle host grant when the host
// has waited too long. Illegal addresses are filtered before reaching memory.
module dmem_arbiter #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2000,
   parameter int AW         = 11,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            core_req_i,
   input  logic            core_we_i,
   input  logic [XLEN-1:0] core_addr_i,
   input  logic [XLEN-1:0] core_wdata_i,
   output logic            core_stall_o,
   output logic            core_rvalid_o,
   output logic [XLEN-1:0] core_rdata_o,
   input  logic            host_req_i,
   input  logic            host_we_i,
   input  logic [XLEN-1:0] host_addr_i,
   input  logic [XLEN-1:0] host_wdata_i,
   output logic            host_gnt_o,
   output logic            host_err_o,
   output logic            host_rvalid_o,
   output logic [XLEN-1:0] host_rdata_o,
   output logic            mem_en_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int              CW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);
   localparam logic [XLEN-1:0] DEPTH_W    = XLEN'(DEPTH);

   typedef enum logic [0:0] {
      CORE_PRI   = 1'b0,
      HOST_FORCE = 1'b1
   } state_t;

   // A byte address is usable only if word aligned and inside the memory.
   function automatic logic addr_legal(input logic [XLEN-1:0] byte_addr);
      logic [XLEN-1:0] word_addr;
      word_addr = {2'b00, byte_addr[XLEN-1:2]};
      return (byte_addr[1:0] == 2'b00) && (word_addr < DEPTH_W);
   endfunction

   state_t        state_r;
   state_t        state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          host_win_s;
   logic          core_win_s;
   logic          core_ok_s;
   logic          host_ok_s;
   logic          core_rd_pend_r;
   logic          core_rd_ok_r;
   logic          host_rd_pend_r;

   assign core_ok_s = addr_legal(core_addr_i);
   assign host_ok_s = addr_legal(host_addr_i);

   // Pick the winner of this cycle's memory slot.
   always_comb begin
      host_win_s = 1'b0;
      core_win_s = 1'b0;
      if (host_req_i && ((state_r == HOST_FORCE) || !core_req_i)) begin
         host_win_s = 1'b1;
      end else if (core_req_i) begin
         core_win_s = 1'b1;
      end else begin
         host_win_s = 1'b0;
         core_win_s = 1'b0;
      end
   end

   // An illegal winner still consumes the slot, but never touches memory.
   assign host_gnt_o   = host_win_s & host_ok_s;
   assign host_err_o   = host_win_s & ~host_ok_s;
   assign core_stall_o = core_req_i & ~core_win_s;

   // Drive the memory port from the winning legal requester.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = {AW{1'b0}};
      mem_wdata_o = {XLEN{1'b0}};
      if (host_win_s && host_ok_s) begin
         mem_en_o    = 1'b1;
         mem_we_o    = host_we_i;
         mem_addr_o  = host_addr_i[AW+1:2];
         mem_wdata_o = host_wdata_i;
      end else if (core_win_s && core_ok_s) begin
         mem_en_o    = 1'b1;
         mem_we_o    = core_we_i;
         mem_addr_o  = core_addr_i[AW+1:2];
         mem_wdata_o = core_wdata_i;
      end else begin
         mem_en_o    = 1'b0;
      end
   end

   // Starvation counter: counts unserved host cycles, clears once served or withdrawn.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (host_win_s) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (host_req_i) begin
         if (cnt_r == STARVE_LIM) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r + CW'(1);
         end
      end else begin
         cnt_nxt_s = {CW{1'b0}};
      end
   end

   // Next-state logic: a saturated counter buys the host one forced slot.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         CORE_PRI: begin
            if ((cnt_r == STARVE_LIM) && host_req_i && !host_win_s) begin
               state_nxt_s = HOST_FORCE;
            end else begin
               state_nxt_s = CORE_PRI;
            end
         end
         HOST_FORCE: begin
            state_nxt_s = CORE_PRI;
         end
         default: begin
            state_nxt_s = CORE_PRI;
         end
      endcase
   end

   // State, counter and read-return flags; reset drops any read in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= CORE_PRI;
         cnt_r          <= {CW{1'b0}};
         core_rd_pend_r <= 1'b0;
         core_rd_ok_r   <= 1'b0;
         host_rd_pend_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         cnt_r          <= cnt_nxt_s;
         core_rd_pend_r <= core_win_s & ~core_we_i;
         core_rd_ok_r   <= core_win_s & ~core_we_i & core_ok_s;
         host_rd_pend_r <= host_win_s & ~host_we_i & host_ok_s;
      end
   end

   assign core_rvalid_o = core_rd_pend_r;
   assign host_rvalid_o = host_rd_pend_r;

   // Return read data to its owner; illegal core reads return zero.
   always_comb begin
      core_rdata_o = {XLEN{1'b0}};
      host_rdata_o = {XLEN{1'b0}};
      if (core_rd_ok_r) begin
         core_rdata_o = mem_rdata_i;
      end else begin
         core_rdata_o = {XLEN{1'b0}};
      end
      if (host_rd_pend_r) begin
         host_rdata_o = mem_rdata_i;
      end else begin
         host_rdata_o = {XLEN{1'b0}};
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected events
// (memory access, grant, error, stall, read returns) tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        core_req_i = 1'b0, core_we_i = 1'b0;
   logic [31:0] core_addr_i = 32'd0, core_wdata_i = 32'd0;
   logic        core_stall_o, core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        host_req_i = 1'b0, host_we_i = 1'b0;
   logic [31:0] host_addr_i = 32'd0, host_wdata_i = 32'd0;
   logic        host_gnt_o, host_err_o, host_rvalid_o;
   logic [31:0] host_rdata_o;
   logic        mem_en_o, mem_we_o;
   logic [10:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = 32'd0;

   logic [31:0] mem [0:2047];
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [10:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t mem_q[$], gnt_q[$], err_q[$], stall_q[$], crv_q[$], hrv_q[$];

   dmem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
      .host_req_i(host_req_i), .host_we_i(host_we_i),
      .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
      .host_gnt_o(host_gnt_o), .host_err_o(host_err_o),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Registered-read memory model.
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata_i <= mem[mem_addr_o];
      end
   end

   function automatic ev_t mk(int c, logic we, logic [10:0] a, logic [31:0] d);
      ev_t e;
      e.cyc = c; e.we = we; e.addr = a; e.data = d;
      return e;
   endfunction

   task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                        input logic rst);
      @(posedge clk_i);
      #1;
      core_req_i = cr; core_we_i = cw; core_addr_i = ca; core_wdata_i = cd;
      host_req_i = hr; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd;
      rst_i = rst;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   // Monitor: every DUT event must match the head of its queue.
   always @(negedge clk_i) begin
      ev_t e;
      if (mem_en_o) begin
         n_cmp = n_cmp + 1;
         if (mem_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL mem_access cyc=%0d got we=%0b addr=%0d wdata=%h required no access", cyc, mem_we_o, mem_addr_o, mem_wdata_o);
         end else begin
            e = mem_q.pop_front();
            if (e.cyc != cyc || e.we !== mem_we_o || e.addr !== mem_addr_o || e.data !== mem_wdata_o) begin
               n_bad = n_bad + 1;
               $display("FAIL mem_access got cyc=%0d we=%0b addr=%0d wdata=%h required cyc=%0d we=%0b addr=%0d wdata=%h",
                        cyc, mem_we_o, mem_addr_o, mem_wdata_o, e.cyc, e.we, e.addr, e.data);
            end
         end
      end
      if (host_gnt_o) begin
         n_cmp = n_cmp + 1;
         if (gnt_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL host_gnt got pulse at cyc=%0d required none", cyc);
         end else begin
            e = gnt_q.pop_front();
            if (e.cyc != cyc) begin
               n_bad = n_bad + 1;
               $display("FAIL host_gnt got cyc=%0d required cyc=%0d", cyc, e.cyc);
            end
         end
      end
      if (host_err_o) begin
         n_cmp = n_cmp + 1;
         if (err_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL host_err got pulse at cyc=%0d required none", cyc);
         end else begin
            e = err_q.pop_front();
            if (e.cyc != cyc) begin
               n_bad = n_bad + 1;
               $display("FAIL host_err got cyc=%0d required cyc=%0d", cyc, e.cyc);
            end
         end
      end
      if (core_stall_o) begin
         n_cmp = n_cmp + 1;
         if (stall_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL core_stall got 1 at cyc=%0d required 0", cyc);
         end else begin
            e = stall_q.pop_front();
            if (e.cyc != cyc) begin
               n_bad = n_bad + 1;
               $display("FAIL core_stall got cyc=%0d required cyc=%0d", cyc, e.cyc);
            end
         end
      end
      if (core_rvalid_o) begin
         n_cmp = n_cmp + 1;
         if (crv_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL core_rvalid got 1 at cyc=%0d rdata=%h required 0", cyc, core_rdata_o);
         end else begin
            e = crv_q.pop_front();
            if (e.cyc != cyc || e.data !== core_rdata_o) begin
               n_bad = n_bad + 1;
               $display("FAIL core_rdata got cyc=%0d data=%h required cyc=%0d data=%h", cyc, core_rdata_o, e.cyc, e.data);
            end
         end
      end else begin
         n_cmp = n_cmp + 1;
         if (core_rdata_o !== 32'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL core_rdata_idle cyc=%0d got %h required 0", cyc, core_rdata_o);
         end
      end
      if (host_rvalid_o) begin
         n_cmp = n_cmp + 1;
         if (hrv_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL host_rvalid got 1 at cyc=%0d rdata=%h required 0", cyc, host_rdata_o);
         end else begin
            e = hrv_q.pop_front();
            if (e.cyc != cyc || e.data !== host_rdata_o) begin
               n_bad = n_bad + 1;
               $display("FAIL host_rdata got cyc=%0d data=%h required cyc=%0d data=%h", cyc, host_rdata_o, e.cyc, e.data);
            end
         end
      end else begin
         n_cmp = n_cmp + 1;
         if (host_rdata_o !== 32'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL host_rdata_idle cyc=%0d got %h required 0", cyc, host_rdata_o);
         end
      end
      if (host_gnt_o && host_err_o) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL gnt_err_both cyc=%0d got both 1 required exclusive", cyc);
      end
   end

   task automatic drain(input string name, inout ev_t q[$]);
      while (q.size() > 0) begin
         ev_t e;
         e = q.pop_front();
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL %s got no event required one at cyc=%0d data=%h", name, e.cyc, e.data);
      end
   endtask

   initial begin
      int b;
      // Reset with idle inputs: no events expected.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      idle();

      // Preload word 4 through the host port.
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0); b = cyc;
      mem_q.push_back(mk(b, 1'b1, 11'd4, 32'hDEADBEEF)); gnt_q.push_back(mk(b, 1'b0, 11'd0, 32'd0));
      idle();

      // Host read with idle core.
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0); b = cyc;
      mem_q.push_back(mk(b, 1'b0, 11'd4, 32'd0)); gnt_q.push_back(mk(b, 1'b0, 11'd0, 32'd0));
      hrv_q.push_back(mk(b + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      idle();

      // Core write then core read back.
      drive(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0); b = cyc;
      mem_q.push_back(mk(b, 1'b1, 11'd8, 32'h12345678));
      mem_q.push_back(mk(b + 1, 1'b0, 11'd8, 32'd0));
      crv_q.push_back(mk(b + 2, 1'b0, 11'd0, 32'h12345678));
      drive(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      idle();

      // Core read and host write collide: core first, host next cycle.
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0); b = cyc;
      mem_q.push_back(mk(b, 1'b0, 11'd4, 32'd0));
      crv_q.push_back(mk(b + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      mem_q.push_back(mk(b + 1, 1'b1, 11'd16, 32'hA5A5A5A5)); gnt_q.push_back(mk(b + 1, 1'b0, 11'd0, 32'd0));
      mem_q.push_back(mk(b + 3, 1'b0, 11'd16, 32'd0));
      crv_q.push_back(mk(b + 4, 1'b0, 11'd0, 32'hA5A5A5A5));
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0);
      idle();
      drive(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      idle();

      // Illegal host addresses, then the last legal word.
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h3, 32'h1, 1'b0); b = cyc;
      err_q.push_back(mk(b, 1'b0, 11'd0, 32'd0));
      err_q.push_back(mk(b + 1, 1'b0, 11'd0, 32'd0));
      mem_q.push_back(mk(b + 2, 1'b1, 11'd1999, 32'h0BADF00D)); gnt_q.push_back(mk(b + 2, 1'b0, 11'd0, 32'd0));
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd8000, 32'h2, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd7996, 32'h0BADF00D, 1'b0);
      idle();

      // Illegal core read returns zero without stall; illegal write is dropped.
      drive(1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0); b = cyc;
      crv_q.push_back(mk(b + 1, 1'b0, 11'd0, 32'd0));
      drive(1'b1, 1'b1, 32'd8000, 32'h77777777, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      idle();

      // Starvation: core held, host read waits, forced grant in cycle 5.
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0); b = cyc;
      for (int i = 0; i < 5; i++) begin
         mem_q.push_back(mk(b + i, 1'b0, 11'd4, 32'd0));
         crv_q.push_back(mk(b + i + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      end
      mem_q.push_back(mk(b + 5, 1'b0, 11'd8, 32'd0)); gnt_q.push_back(mk(b + 5, 1'b0, 11'd0, 32'd0));
      stall_q.push_back(mk(b + 5, 1'b0, 11'd0, 32'd0));
      hrv_q.push_back(mk(b + 6, 1'b0, 11'd0, 32'h12345678));
      mem_q.push_back(mk(b + 6, 1'b0, 11'd4, 32'd0));
      crv_q.push_back(mk(b + 7, 1'b0, 11'd0, 32'hDEADBEEF));
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      idle();

      // Reset mid-starvation: read under reset returns nothing, counter restarts.
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h44, 32'h11111111, 1'b0); b = cyc;
      for (int i = 0; i < 3; i++) begin
         mem_q.push_back(mk(b + i, 1'b0, 11'd4, 32'd0));
         crv_q.push_back(mk(b + i + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      end
      mem_q.push_back(mk(b + 3, 1'b0, 11'd8, 32'd0));
      for (int i = 4; i < 9; i++) begin
         mem_q.push_back(mk(b + i, 1'b0, 11'd4, 32'd0));
         crv_q.push_back(mk(b + i + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      end
      mem_q.push_back(mk(b + 9, 1'b1, 11'd17, 32'h11111111)); gnt_q.push_back(mk(b + 9, 1'b0, 11'd0, 32'd0));
      stall_q.push_back(mk(b + 9, 1'b0, 11'd0, 32'd0));
      for (int i = 1; i <= 2; i++) drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h44, 32'h11111111, 1'b0);
      drive(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, 1'b1, 32'h44, 32'h11111111, 1'b1);
      for (int i = 4; i <= 9; i++) drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h44, 32'h11111111, 1'b0);
      idle();

      // Host withdraws before grant: counter restarts from zero.
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h48, 32'h22222222, 1'b0); b = cyc;
      for (int i = 0; i < 9; i++) begin
         mem_q.push_back(mk(b + i, 1'b0, 11'd4, 32'd0));
         crv_q.push_back(mk(b + i + 1, 1'b0, 11'd0, 32'hDEADBEEF));
      end
      mem_q.push_back(mk(b + 9, 1'b1, 11'd18, 32'h22222222)); gnt_q.push_back(mk(b + 9, 1'b0, 11'd0, 32'd0));
      stall_q.push_back(mk(b + 9, 1'b0, 11'd0, 32'd0));
      for (int i = 1; i <= 2; i++) drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h48, 32'h22222222, 1'b0);
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 4; i <= 9; i++) drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h48, 32'h22222222, 1'b0);
      idle();
      idle();
      idle();

      @(negedge clk_i);
      #1;
      drain("mem_access", mem_q);
      drain("host_gnt", gnt_q);
      drain("host_err", err_q);
      drain("core_stall", stall_q);
      drain("core_rvalid", crv_q);
      drain("host_rvalid", hrv_q);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter DEPTH, default 2000, data memory size in words.
REQ-003 Parameter AW, default 11, memory word-address width (2^AW >= DEPTH).
REQ-004 Parameter STARVE_MAX, default 4, host wait cycles before a forced host grant.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports (name  direction  width  meaning):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  M-stage memory access request
- core_we_i  in  1  core write enable
- core_addr_i  in  XLEN  core byte address
- core_wdata_i  in  XLEN  core write data
- core_stall_o  out  1  core request not served this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  XLEN  core read data
- host_req_i  in  1  host access request, held until grant or error
- host_we_i  in  1  host write enable
- host_addr_i  in  XLEN  host byte address
- host_wdata_i  in  XLEN  host write data
- host_gnt_o  out  1  host request accepted (1-cycle pulse)
- host_err_o  out  1  host request rejected (1-cycle pulse)
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  XLEN  host read data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory word address (byte address >> 2)
- mem_wdata_o  out  XLEN  memory write data
- mem_rdata_i  in  XLEN  memory read data, registered, valid one cycle after mem_en_o

Function
REQ-007 One memory access SHALL be issued per cycle at most; the winner drives mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o combinationally in that cycle.
REQ-008 FSM states: CORE_PRI (default), HOST_FORCE; state is registered.
REQ-009 In CORE_PRI, core_req_i SHALL win; host wins only when core_req_i=0.
REQ-010 Starvation counter (width clog2(STARVE_MAX+1)) SHALL increment each cycle host_req_i=1 and host is not served, saturate at STARVE_MAX, and clear on host grant or error.
REQ-011 Counter reaching STARVE_MAX SHALL move the FSM to HOST_FORCE next cycle; in HOST_FORCE the host SHALL win for exactly one cycle, then the FSM returns to CORE_PRI.
REQ-012 core_stall_o = core_req_i AND core not served this cycle; the core SHALL hold request signals while stalled.
REQ-013 Read latency SHALL be 1 cycle: a read granted in cycle N asserts the winner's rvalid in cycle N+1 with rdata = mem_rdata_i; the other rvalid stays 0.
REQ-014 Writes SHALL produce no rvalid; host_gnt_o pulses in the accept cycle for both reads and writes.
REQ-015 Address checks: byte address [1:0] != 0 or word address >= DEPTH is illegal.
REQ-016 Illegal host request SHALL pulse host_err_o in the cycle it would have been served, with no memory access and no host_gnt_o.
REQ-017 Illegal core request SHALL not stall; the cycle SHALL be consumed with mem_en_o=0 and, for reads, core_rvalid_o=1 with core_rdata_o=0 next cycle.
REQ-018 host_gnt_o and host_err_o SHALL never be asserted together; both SHALL stay 0 while host_req_i=0.
REQ-019 core_rdata_o/host_rdata_o SHALL be 0 when the corresponding rvalid is 0.
REQ-020 A host request withdrawn before grant SHALL clear the starvation counter the next cycle.

Reset
REQ-021 rst_i=1 at a clock edge SHALL set FSM=CORE_PRI, counter=0, and pending rvalid flags=0.
REQ-022 During and after reset until the next request: all outputs 0, except core_stall_o, which follows REQ-012.
REQ-023 A read granted in the cycle rst_i is asserted SHALL produce no rvalid.

Verification
REQ-024 Idle core; host read addr 0x10, mem word 4 = 0xDEADBEEF -> host_gnt_o same cycle, host_rvalid_o=1 and host_rdata_o=0xDEADBEEF next cycle.
REQ-025 Core req held continuously, host req from cycle 0 -> host waits 4 cycles, FSM enters HOST_FORCE, host granted in cycle 5, core_stall_o=1 only in cycle 5.
REQ-026 Core read and host write in the same cycle, counter 0 -> core served and core_rvalid_o next cycle; host write delayed with mem_we_o=0 in that cycle.
REQ-027 Host write to 0x00000003, then to 8000 (word 2000) -> host_err_o pulses each time, mem_en_o=0, no host_gnt_o.
REQ-028 Core read granted, rst_i=1 same cycle -> core_rvalid_o=0 next cycle, counter=0, FSM=CORE_PRI.
REQ-029 Core write 0x12345678 at 0x20, then core read at 0x20 -> mem_we_o=1 with mem_addr_o=8, then core_rdata_o=0x12345678 one cycle after the read grant.
